adc_sample_scheduler: RTL and testbench

Sequences conversions on the shared 12-bit serial ADC read engine and time-shares it between two requesters (the primary and twin circuit under test). Each requester asks for a burst of conversions; the block arbitrates round-robin, issues per-conversion start pulses with a programmable inter-sample gap, and returns tagged samples. It sits between the capture logic of the data collector and the ADC read engine.

---
 rtl/adc_sample_scheduler.sv | 153 +++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// Round-robin burst scheduler for the shared serial ADC read engine.
// Two requesters each get bursts of conversions with a gap between them, timeout protection and tagged samples.
module adc_sample_scheduler #(
   parameter int DATA_W  = 12,
   parameter int BURST_W = 8,
   parameter int GAP_W   = 8,
   parameter int TIMEOUT = 64
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [GAP_W-1:0]  gap,
   output logic              conv_start,
   input  logic              conv_done,
   input  logic [DATA_W-1:0] conv_data,
   output logic [1:0]        grant,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_id,
   output logic              out_last,
   output logic [1:0]        burst_done,
   output logic              timeout_err
);
   localparam int WC_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, WAIT, GAP, DONE} state_t;

   state_t            state, state_n;
   logic              owner, owner_n;
   logic              last_srv, last_srv_n;
   logic [BURST_W:0]  len_q, len_n, cnt, cnt_n, cnt_inc;
   logic [GAP_W-1:0]  gap_q, gap_n, gcnt, gcnt_n;
   logic [WC_W-1:0]   wcnt, wcnt_n;
   logic [1:0]        grant_n, burst_done_n;
   logic              conv_start_n, out_valid_n, out_last_n, out_id_n, timeout_err_n;
   logic [DATA_W-1:0] out_data_n;
   logic              pick;

   assign cnt_inc = cnt + 1'b1;
   // On contention the requester not served last wins; otherwise whoever asks.
   assign pick = (req0 && req1) ? ~last_srv : req1;

   always_comb begin
      state_n       = state;
      owner_n       = owner;
      last_srv_n    = last_srv;
      len_n         = len_q;
      cnt_n         = cnt;
      gap_n         = gap_q;
      gcnt_n        = gcnt;
      wcnt_n        = wcnt;
      grant_n       = grant;
      burst_done_n  = 2'b00;
      conv_start_n  = 1'b0;
      out_valid_n   = 1'b0;
      out_last_n    = 1'b0;
      out_id_n      = out_id;
      out_data_n    = out_data;
      timeout_err_n = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               owner_n      = pick;
               grant_n      = pick ? 2'b10 : 2'b01;
               len_n        = (burst_len == '0) ? (BURST_W+1)'(1) : {1'b0, burst_len};
               gap_n        = gap;
               cnt_n        = '0;
               wcnt_n       = '0;
               conv_start_n = 1'b1;
               state_n      = WAIT;
            end
         end
         WAIT: begin
            wcnt_n = wcnt + 1'b1;
            // A sample arriving on the timeout cycle is still accepted.
            if (conv_done) begin
               out_data_n  = conv_data;
               out_valid_n = 1'b1;
               out_id_n    = owner;
               cnt_n       = cnt_inc;
               if (cnt_inc == len_q) begin
                  out_last_n = 1'b1;
                  state_n    = DONE;
               end else if (gap_q == '0) begin
                  conv_start_n = 1'b1;
                  wcnt_n       = '0;
               end else begin
                  gcnt_n  = gap_q;
                  state_n = GAP;
               end
            end else if (wcnt == WC_W'(TIMEOUT - 1)) begin
               timeout_err_n = 1'b1;
               state_n       = DONE;
            end
         end
         GAP: begin
            gcnt_n = gcnt - 1'b1;
            if (gcnt == GAP_W'(1)) begin
               conv_start_n = 1'b1;
               wcnt_n       = '0;
               state_n      = WAIT;
            end
         end
         DONE: begin
            burst_done_n = owner ? 2'b10 : 2'b01;
            grant_n      = 2'b00;
            last_srv_n   = owner;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_srv    <= 1'b1;
         len_q       <= '0;
         cnt         <= '0;
         gap_q       <= '0;
         gcnt        <= '0;
         wcnt        <= '0;
         grant       <= 2'b00;
         burst_done  <= 2'b00;
         conv_start  <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_id      <= 1'b0;
         out_data    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         last_srv    <= last_srv_n;
         len_q       <= len_n;
         cnt         <= cnt_n;
         gap_q       <= gap_n;
         gcnt        <= gcnt_n;
         wcnt        <= wcnt_n;
         grant       <= grant_n;
         burst_done  <= burst_done_n;
         conv_start  <= conv_start_n;
         out_valid   <= out_valid_n;
         out_last    <= out_last_n;
         out_id      <= out_id_n;
         out_data    <= out_data_n;
         timeout_err <= timeout_err_n;
      end
   end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench: tests push expected samples/burst_done, a negedge monitor pops and compares.
module tb_adc_sample_scheduler;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [7:0]  burst_len = 8'd1, gap = 8'd0;
   logic        conv_start, conv_done, out_valid, out_id, out_last, timeout_err;
   logic [11:0] conv_data, out_data;
   logic [1:0]  grant, burst_done;

   adc_sample_scheduler dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .burst_len(burst_len), .gap(gap),
      .conv_start(conv_start), .conv_done(conv_done), .conv_data(conv_data), .grant(grant),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last),
      .burst_done(burst_done), .timeout_err(timeout_err));

   always #5 clk = ~clk;

   typedef struct { logic id; logic [11:0] data; logic last; } exp_t;
   exp_t        exp_q[$];
   logic [1:0]  bd_q[$];
   logic [11:0] eng_q[$];

   int  checks = 0, failures = 0, cyc = 0;
   int  last_start = 0, prev_start = 0, lat = 5, rem = 0;
   bit  eng_en = 1'b1, busy = 1'b0, spur = 1'b0, prev_last = 1'b0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Read-engine model: answers each conv_start with conv_done after lat cycles.
   initial begin
      conv_done = 1'b0;
      conv_data = '0;
      forever begin
         @(negedge clk);
         conv_done = 1'b0;
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (spur) begin
               conv_done = 1'b1;
               conv_data = 12'h5A5;
               spur      = 1'b0;
            end else if (busy) begin
               rem--;
               if (rem == 0) begin
                  conv_done = 1'b1;
                  conv_data = (eng_q.size() != 0) ? eng_q.pop_front() : 12'hFFF;
                  busy      = 1'b0;
               end
            end
            if (conv_start) begin
               chk("start_while_busy", 32'(busy), 0);
               prev_start = last_start;
               last_start = cyc;
               if (eng_en) begin
                  busy = 1'b1;
                  rem  = lat;
               end
            end
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_last <= 1'b0;
      end else begin
         if (prev_last) chk("bd_after_last", 32'(burst_done != 2'b00), 1);
         if (out_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'(out_valid), 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_id",   32'(out_id),   32'(e.id));
               chk("out_last", 32'(out_last), 32'(e.last));
            end
         end
         if (burst_done != 2'b00) begin
            if (bd_q.size() == 0) chk("bd_unexpected", 32'(burst_done), 0);
            else chk("burst_done", 32'(burst_done), 32'(bd_q.pop_front()));
            chk("grant_cleared", 32'(grant), 0);
         end
         prev_last <= out_valid && out_last;
      end
   end

   task automatic push_burst(input logic id, input int n, input logic [11:0] base);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.id   = id;
         e.data = base + 12'(i);
         e.last = (i == n - 1);
         eng_q.push_back(e.data);
         exp_q.push_back(e);
      end
      bd_q.push_back(id ? 2'b10 : 2'b01);
   endtask

   task automatic wait_bd(input int maxc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (burst_done == 2'b00 && n < maxc);
      chk("bd_wait", 32'(burst_done != 2'b00), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_conv_start", 32'(conv_start), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_burst_done", 32'(burst_done), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      rst = 1'b0;

      // Contention after reset: 0 first, then 1, then held req0 again.
      @(negedge clk);
      burst_len = 8'd2; gap = 8'd0; lat = 3;
      push_burst(1'b0, 2, 12'h010);
      push_burst(1'b1, 2, 12'h020);
      push_burst(1'b0, 2, 12'h030);
      req0 = 1'b1; req1 = 1'b1;
      wait_bd(100);
      wait_bd(100); req1 = 1'b0;
      wait_bd(100); req0 = 1'b0;

      // req0 only, len 3, gap 0, latency 5.
      repeat (2) @(negedge clk);
      burst_len = 8'd3; gap = 8'd0; lat = 5;
      push_burst(1'b0, 3, 12'h100);
      req0 = 1'b1;
      @(posedge clk); #1;
      chk("grant_latency", 32'(grant), 1);
      chk("start_latency", 32'(conv_start), 1);
      wait_bd(100); req0 = 1'b0;
      chk("spacing_gap0", 32'(last_start - prev_start), 6);

      // gap 4, len 2 on requester 1.
      repeat (2) @(negedge clk);
      burst_len = 8'd2; gap = 8'd4;
      push_burst(1'b1, 2, 12'h200);
      req1 = 1'b1;
      wait_bd(100); req1 = 1'b0;
      chk("spacing_gap4", 32'(last_start - prev_start), 10);

      // burst_len 0 behaves as a single conversion; stray conv_done in IDLE ignored.
      repeat (2) @(negedge clk);
      burst_len = 8'd0; gap = 8'd0;
      push_burst(1'b0, 1, 12'h7E1);
      req0 = 1'b1;
      wait_bd(100); req0 = 1'b0;
      repeat (2) @(negedge clk);
      spur = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("spur_no_valid", 32'(out_valid), 0);
      end

      // Engine never answers: timeout after 64 cycles.
      eng_en = 1'b0;
      burst_len = 8'd2;
      bd_q.push_back(2'b10);
      req1 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 120 && !seen; i++) begin
         @(negedge clk);
         if (timeout_err) seen = 1'b1;
      end
      req1 = 1'b0;
      chk("timeout_seen", 32'(seen), 1);
      chk("timeout_latency", 32'(cyc - last_start), 64);
      @(negedge clk);
      chk("timeout_pulse", 32'(timeout_err), 0);
      chk("timeout_bd", 32'(burst_done), 2);
      @(negedge clk);
      chk("timeout_grant", 32'(grant), 0);
      eng_en = 1'b1;

      // Async reset in WAIT, then a fresh grant.
      burst_len = 8'd1; lat = 20;
      push_burst(1'b0, 1, 12'h3C0);
      req0 = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_grant", 32'(grant), 0);
      chk("arst_out_data", 32'(out_data), 0);
      chk("arst_out_id", 32'(out_id), 0);
      chk("arst_out_last", 32'(out_last), 0);
      chk("arst_conv_start", 32'(conv_start), 0);
      exp_q.delete(); bd_q.delete(); eng_q.delete();
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      lat = 4;
      push_burst(1'b0, 1, 12'h3C5);
      req0 = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_grant", 32'(grant), 1);
      chk("post_rst_start", 32'(conv_start), 1);
      wait_bd(100); req0 = 1'b0;

      repeat (4) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 0);
      chk("bd_q_drained", 32'(bd_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
